// File: rtl/store_buffer_if.sv
// Store-buffer bus bundle: CPU store channel, load-forwarding port and
// data-memory write/read port, grouped so they travel as one connection.
//   CPU side : st_valid/st_addr/st_data/st_whb in, st_ready/st_misalign out
//   Load side: ld_addr in, ld_data out (memory word with pending stores merged)
//   Memory   : DMWr/address/din/STOREwhb out, drain_en/dout in
// The buffer itself connects through the slave modport; the CPU/memory
// environment connects through master.
interface store_buffer_if;
  logic        st_valid;
  logic [8:0]  st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_whb;
  logic        st_ready;
  logic        st_misalign;

  logic [8:0]  ld_addr;
  logic [31:0] ld_data;

  logic        drain_en;
  logic        DMWr;
  logic [8:0]  address;
  logic [31:0] din;
  logic [1:0]  STOREwhb;
  logic [31:0] dout;

  modport slave (
    input  st_valid, st_addr, st_data, st_whb, ld_addr, drain_en, dout,
    output st_ready, st_misalign, ld_data, DMWr, address, din, STOREwhb
  );

  modport master (
    output st_valid, st_addr, st_data, st_whb, ld_addr, drain_en, dout,
    input  st_ready, st_misalign, ld_data, DMWr, address, din, STOREwhb
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store buffer between the CPU and a single-port data memory.
// Stores are queued (up to DEPTH), drained one per cycle whenever the
// memory write port is free, and younger loads see pending stores merged
// on top of the memory read word.
//   clk, rst : clock and synchronous active-high reset
//   sb       : store_buffer_if.slave (store channel, forwarding, memory port)
//   empty    : no stores pending
//   count    : number of stores pending (0..DEPTH)
// STOREwhb encoding: 2'b00 word, 2'b01 halfword, 2'b10 byte; 2'b11 is
// queued and written through but never merged into load data.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  store_buffer_if.slave  sb,
  output logic           empty,
  output logic [3:0]     count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] WHB_SW = 2'b00;
  localparam logic [1:0] WHB_SH = 2'b01;
  localparam logic [1:0] WHB_SB = 2'b10;

  typedef struct packed {
    logic [8:0]  addr;
    logic [31:0] data;
    logic [1:0]  whb;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               misalign;
  logic               full;
  logic               is_empty;
  logic               push;
  logic               pop;
  entry_t             head;
  logic [31:0]        merged;

  // Alignment check on the incoming request
  always_comb begin
    misalign = 1'b0;
    if (sb.st_valid) begin
      case (sb.st_whb)
        WHB_SW:  misalign = (sb.st_addr[1:0] != 2'b00);
        WHB_SH:  misalign = sb.st_addr[0];
        default: misalign = 1'b0;
      endcase
    end
  end

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign is_empty = (cnt_q == '0);

  // Ready is purely occupancy-based so it never loops through drain_en.
  assign push = sb.st_valid & ~full & ~misalign;
  // rst masks the drain so a reset cycle never writes memory.
  assign pop  = sb.drain_en & ~is_empty & ~rst;

  assign head = mem_q[rd_ptr_q];

  assign sb.st_ready    = ~full;
  assign sb.st_misalign = misalign;
  assign sb.DMWr        = pop;
  assign sb.address     = is_empty ? 9'd0  : head.addr;
  assign sb.din         = is_empty ? 32'd0 : head.data;
  assign sb.STOREwhb    = is_empty ? 2'd0  : head.whb;

  assign empty = is_empty;
  assign count = cnt_q;

  // FIFO pointers, occupancy and entry storage
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{addr: sb.st_addr, data: sb.st_data, whb: sb.st_whb};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Load forwarding: walk entries oldest to youngest so the youngest
  // matching store wins each byte. The head stays in the overlay even
  // while it drains, since memory only updates at the edge.
  always_comb begin
    entry_t           e;
    logic [PTR_W-1:0] idx;
    merged = sb.dout;
    e      = '0;
    idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      e   = mem_q[idx];
      if (!rst && (CNT_W'(i) < cnt_q) && (e.addr[8:2] == sb.ld_addr[8:2])) begin
        case (e.whb)
          WHB_SW: merged = e.data;
          WHB_SH: merged[{e.addr[1], 4'b0000} +: 16] = e.data[15:0];
          WHB_SB: merged[{e.addr[1:0], 3'b000} +: 8] = e.data[7:0];
          default: ;
        endcase
      end
    end
  end

  assign sb.ld_data = merged;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer (DEPTH=4): a table of store/drain
// vectors with hand-derived expectations, hand-written corner sequences,
// and a queue scoreboard that tracks pending stores, checks every memory
// write against the expected order and predicts forwarded load data.
module tb_store_buffer;

  localparam logic [1:0] SW = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SB = 2'b10;
  localparam int         DEPTH = 4;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
    logic [1:0]  whb;
  } st_t;

  typedef struct {
    logic        valid;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [1:0]  whb;
    logic        drain;
    logic        exp_mis;
    int          exp_cnt;
    logic        exp_rdy;
    logic        exp_dmwr;
    logic        chk_ld;
    logic [31:0] exp_ld;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       empty;
  logic [3:0] count;

  store_buffer_if sbif ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .sb    (sbif),
    .empty (empty),
    .count (count)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  st_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference merge over the pending-store queue, oldest first
  function automatic logic [31:0] model_ld(input logic [31:0] base, input logic [8:0] la);
    logic [31:0] r;
    r = base;
    foreach (exp_q[k]) begin
      if (exp_q[k].addr[8:2] == la[8:2]) begin
        if (exp_q[k].whb == SW) r = exp_q[k].data;
        else if (exp_q[k].whb == SH) begin
          if (exp_q[k].addr[1]) r[31:16] = exp_q[k].data[15:0];
          else                  r[15:0]  = exp_q[k].data[15:0];
        end else if (exp_q[k].whb == SB) begin
          case (exp_q[k].addr[1:0])
            2'd0: r[7:0]   = exp_q[k].data[7:0];
            2'd1: r[15:8]  = exp_q[k].data[7:0];
            2'd2: r[23:16] = exp_q[k].data[7:0];
            default: r[31:24] = exp_q[k].data[7:0];
          endcase
        end
      end
    end
    return r;
  endfunction

  // One clock cycle: drive inputs, check combinational outputs against the
  // scoreboard, clock the edge, then update the scoreboard.
  task automatic cycle(input logic r, input logic v, input logic [8:0] a,
                       input logic [31:0] d, input logic [1:0] w, input logic dr,
                       input logic [8:0] la, input logic [31:0] dmw);
    logic exp_mis, exp_rdy, exp_dmwr, accept;
    rst           = r;
    sbif.st_valid = v;
    sbif.st_addr  = a;
    sbif.st_data  = d;
    sbif.st_whb   = w;
    sbif.drain_en = dr;
    sbif.ld_addr  = la;
    sbif.dout     = dmw;
    #1;
    exp_rdy  = (exp_q.size() < DEPTH);
    exp_mis  = v && (((w == SW) && (a[1:0] != 2'b00)) || ((w == SH) && a[0]));
    exp_dmwr = dr && (exp_q.size() > 0) && !r;
    chk("st_misalign", 32'(sbif.st_misalign), 32'(exp_mis));
    chk("st_ready", 32'(sbif.st_ready), 32'(exp_rdy));
    chk("DMWr", 32'(sbif.DMWr), 32'(exp_dmwr));
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("empty", 32'(empty), 32'(exp_q.size() == 0));
    if (exp_q.size() > 0) begin
      chk("address", 32'(sbif.address), 32'(exp_q[0].addr));
      chk("din", sbif.din, exp_q[0].data);
      chk("STOREwhb", 32'(sbif.STOREwhb), 32'(exp_q[0].whb));
    end else begin
      chk("address_idle", 32'(sbif.address), 32'd0);
      chk("din_idle", sbif.din, 32'd0);
    end
    if (!r) chk("ld_data", sbif.ld_data, model_ld(dmw, la));
    accept = v && exp_rdy && !exp_mis && !r;
    @(posedge clk);
    #1;
    if (r) exp_q.delete();
    else begin
      if (exp_dmwr) void'(exp_q.pop_front());
      if (accept) exp_q.push_back('{addr: a, data: d, whb: w});
    end
  endtask

  task automatic idle(input logic dr, input logic [8:0] la, input logic [31:0] dmw);
    cycle(1'b0, 1'b0, 9'd0, 32'd0, SW, dr, la, dmw);
  endtask

  task automatic drain_all();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) idle(1'b1, 9'd0, 32'd0);
    chk("drain_empty", 32'(empty), 32'd1);
  endtask

  vec_t vt[16];

  initial begin
    // Fill/drain, misalign and mixed-width vectors
    vt[0]  = '{1, 9'h000, 32'h11111111, SW, 0, 0, 0, 1, 0, 0, 32'h0};
    vt[1]  = '{1, 9'h004, 32'h22222222, SW, 0, 0, 1, 1, 0, 0, 32'h0};
    vt[2]  = '{1, 9'h008, 32'h33333333, SW, 0, 0, 2, 1, 0, 0, 32'h0};
    vt[3]  = '{1, 9'h00C, 32'h44444444, SW, 0, 0, 3, 1, 0, 0, 32'h0};
    vt[4]  = '{1, 9'h020, 32'h55555555, SW, 0, 0, 4, 0, 0, 0, 32'h0};
    vt[5]  = '{0, 9'h000, 32'h0,        SW, 1, 0, 4, 0, 1, 0, 32'h0};
    vt[6]  = '{0, 9'h000, 32'h0,        SW, 1, 0, 3, 1, 1, 0, 32'h0};
    vt[7]  = '{0, 9'h000, 32'h0,        SW, 1, 0, 2, 1, 1, 0, 32'h0};
    vt[8]  = '{0, 9'h000, 32'h0,        SW, 1, 0, 1, 1, 1, 0, 32'h0};
    vt[9]  = '{0, 9'h000, 32'h0,        SW, 1, 0, 0, 1, 0, 0, 32'h0};
    vt[10] = '{1, 9'h002, 32'h66666666, SW, 1, 1, 0, 1, 0, 0, 32'h0};
    vt[11] = '{1, 9'h003, 32'h00007777, SH, 1, 1, 0, 1, 0, 0, 32'h0};
    vt[12] = '{0, 9'h003, 32'h0,        SW, 1, 0, 0, 1, 0, 0, 32'h0};
    vt[13] = '{1, 9'h002, 32'h0000BEEF, SH, 0, 0, 0, 1, 0, 0, 32'h0};
    vt[14] = '{1, 9'h003, 32'h000000A5, SB, 0, 0, 1, 1, 0, 0, 32'h0};
    vt[15] = '{0, 9'h000, 32'h0,        SW, 0, 0, 2, 1, 0, 1, 32'hA5EF0304};

    rst           = 1'b1;
    sbif.st_valid = 1'b0;
    sbif.st_addr  = '0;
    sbif.st_data  = '0;
    sbif.st_whb   = SW;
    sbif.drain_en = 1'b0;
    sbif.ld_addr  = '0;
    sbif.dout     = 32'hDEADBEEF;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_ready", 32'(sbif.st_ready), 32'd1);
    chk("reset_dmwr", 32'(sbif.DMWr), 32'd0);
    chk("reset_ld", sbif.ld_data, 32'hDEADBEEF);
    @(posedge clk);
    #1;

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      rst           = 1'b0;
      sbif.st_valid = vt[i].valid;
      sbif.st_addr  = vt[i].addr;
      sbif.st_data  = vt[i].data;
      sbif.st_whb   = vt[i].whb;
      sbif.drain_en = vt[i].drain;
      sbif.ld_addr  = 9'h000;
      sbif.dout     = 32'h01020304;
      #1;
      chk($sformatf("vec%0d_mis", i), 32'(sbif.st_misalign), 32'(vt[i].exp_mis));
      chk($sformatf("vec%0d_cnt", i), 32'(count), 32'(vt[i].exp_cnt));
      chk($sformatf("vec%0d_rdy", i), 32'(sbif.st_ready), 32'(vt[i].exp_rdy));
      chk($sformatf("vec%0d_dmwr", i), 32'(sbif.DMWr), 32'(vt[i].exp_dmwr));
      if (vt[i].chk_ld) chk($sformatf("vec%0d_ld", i), sbif.ld_data, vt[i].exp_ld);
      cycle(1'b0, vt[i].valid, vt[i].addr, vt[i].data, vt[i].whb, vt[i].drain,
            9'h000, 32'h01020304);
    end
    drain_all();

    // Forwarding merge, including the entry draining this cycle
    cycle(1'b0, 1'b1, 9'h011, 32'h0000005A, SB, 1'b0, 9'h010, 32'hAABBCCDD);
    cycle(1'b0, 1'b1, 9'h012, 32'h00001234, SH, 1'b0, 9'h010, 32'hAABBCCDD);
    sbif.st_valid = 1'b0;
    #1;
    chk("fwd_merge", sbif.ld_data, 32'h12345ADD);
    sbif.ld_addr = 9'h014;
    #1;
    chk("fwd_other_word", sbif.ld_data, 32'hAABBCCDD);
    sbif.ld_addr  = 9'h010;
    sbif.drain_en = 1'b1;
    #1;
    chk("fwd_draining_dmwr", 32'(sbif.DMWr), 32'd1);
    chk("fwd_draining", sbif.ld_data, 32'h12345ADD);
    idle(1'b1, 9'h010, 32'hAABBCCDD);
    drain_all();
    cycle(1'b0, 1'b1, 9'h010, 32'hCAFEF00D, SW, 1'b0, 9'h010, 32'h0);
    cycle(1'b0, 1'b1, 9'h010, 32'h00000099, SB, 1'b0, 9'h010, 32'h0);
    sbif.st_valid = 1'b0;
    #1;
    chk("fwd_youngest", sbif.ld_data, 32'hCAFEF099);
    drain_all();

    // Simultaneous push and pop at count 2
    cycle(1'b0, 1'b1, 9'h100, 32'hA0A0A0A0, SW, 1'b0, 9'h0, 32'h0);
    cycle(1'b0, 1'b1, 9'h104, 32'hB1B1B1B1, SW, 1'b0, 9'h0, 32'h0);
    cycle(1'b0, 1'b1, 9'h108, 32'hC2C2C2C2, SW, 1'b1, 9'h0, 32'h0);
    chk("pushpop_count", 32'(count), 32'd2);
    drain_all();

    // Reset with stores pending: none may reach memory
    cycle(1'b0, 1'b1, 9'h040, 32'h0BAD0001, SW, 1'b0, 9'h0, 32'h0);
    cycle(1'b0, 1'b1, 9'h044, 32'h0BAD0002, SW, 1'b0, 9'h0, 32'h0);
    cycle(1'b0, 1'b1, 9'h048, 32'h0BAD0003, SW, 1'b0, 9'h0, 32'h0);
    cycle(1'b1, 1'b1, 9'h04C, 32'h0BAD0004, SW, 1'b1, 9'h0, 32'h0);
    rst           = 1'b0;
    sbif.st_valid = 1'b0;
    #1;
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_empty", 32'(empty), 32'd1);
    chk("rst_mid_dmwr", 32'(sbif.DMWr), 32'd0);
    for (int k = 0; k < 3; k++) idle(1'b1, 9'h040, 32'h0);

    // Pointer wrap with interleaved push/pop
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 9'(9'h080 + 4 * i), $urandom, SW, (i % 3) != 2, 9'h080, 32'h0);
    end
    drain_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
